// File: rtl/tt_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker_if
//
// Purpose: bundles every non-clock signal of the truth-table sweep checker.
//          This covers the harness control/report side and the drive/observe
//          side of the combinational logic block under test.
//
// Signals (directions as seen by the checker, i.e. the slave modport):
//   start       in   request a sweep (accepted only when idle)
//   abort       in   synchronous cancel of a running sweep
//   expected    in   TW-bit expected table, bit k = output for vector k
//   dut_out     in   output of the logic block
//   dut_in      out  N_IN-bit vector driven into the logic block
//   busy        out  high while a sweep runs
//   done        out  one-cycle completion pulse
//   pass        out  measured table matched the latched expected table
//   meas_table  out  measured table, bit k = dut_out sampled for vector k
//   err_count   out  number of mismatching rows (N_IN+1 bits)
//   first_err   out  lowest mismatching vector index (0 when no errors)
//
// The measured table is called meas_table because "table" is a reserved
// word in SystemVerilog.
// ---------------------------------------------------------------------------
interface tt_sweep_checker_if #(
    parameter int N_IN = 3
);
    localparam int TW = 2 ** N_IN;

    logic            start;
    logic            abort;
    logic [TW-1:0]   expected;
    logic            dut_out;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [TW-1:0]   meas_table;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err;

    // Harness plus logic-block side: drives requests and the block output.
    modport master (
        output start, abort, expected, dut_out,
        input  dut_in, busy, done, pass, meas_table, err_count, first_err
    );

    // Checker side.
    modport slave (
        input  start, abort, expected, dut_out,
        output dut_in, busy, done, pass, meas_table, err_count, first_err
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker
//
// Purpose: sweeps every input vector 0..2^N_IN-1 into an N_IN-input,
//          1-output combinational logic block. Each vector is held for
//          SETTLE_CYCLES cycles and the block output is sampled on the last
//          of them. The measured truth table is built up row by row and
//          compared against an expected table that is latched at start.
//
// Parameters:
//   N_IN           number of logic-block inputs (table width TW = 2**N_IN)
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..255)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of tt_sweep_checker_if (control, results and
//         logic-block drive/observe signals)
// ---------------------------------------------------------------------------
module tt_sweep_checker #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    tt_sweep_checker_if.slave bus
);
    localparam int              TW       = 2 ** N_IN;
    localparam logic [7:0]      CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;

    logic [N_IN-1:0] r_vec;
    logic [7:0]      r_cnt;
    logic [TW-1:0]   r_expected;
    logic [TW-1:0]   r_table;
    logic [N_IN:0]   r_errCount;
    logic [N_IN-1:0] r_firstErr;
    logic            r_pass;

    logic            w_sampleEdge;
    logic            w_mismatch;
    logic [N_IN:0]   w_errNext;

    // Sampling happens on the last settle cycle of the current vector.
    // An abort in the same cycle wins, so that row is never captured.
    always_comb begin
        w_sampleEdge = (r_state == ST_RUN) && !bus.abort && (r_cnt == CNT_LAST);
        w_mismatch   = (bus.dut_out != r_expected[r_vec]);
        w_errNext    = r_errCount + {{N_IN{1'b0}}, w_mismatch};
    end

    // State register. The asynchronous reset returns to IDLE at any time,
    // including in the middle of a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Start is only looked at in IDLE, so a start that
    // arrives during RUN or FIN is dropped rather than queued. FIN always
    // lasts exactly one cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_stateNext = ST_IDLE;
                end else if (w_sampleEdge && (r_vec == VEC_LAST)) begin
                    w_stateNext = ST_FIN;
                end
            end
            ST_FIN: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Output logic. The logic block only sees the sweep vector while RUN is
    // active and is parked at 0 otherwise. The result fields come straight
    // from their registers, so they hold their values until the next start.
    always_comb begin
        bus.dut_in     = (r_state == ST_RUN) ? r_vec : '0;
        bus.busy       = (r_state == ST_RUN);
        bus.done       = (r_state == ST_FIN);
        bus.pass       = r_pass;
        bus.meas_table = r_table;
        bus.err_count  = r_errCount;
        bus.first_err  = r_firstErr;
    end

    // Sweep datapath: vector and settle counters, captured table and the
    // error bookkeeping.
    // - first_err is written only when the pre-increment error count is
    //   still zero, so it records the lowest failing vector.
    // - pass is resolved at the edge that enters FIN, using the error count
    //   that already includes the final row. It is therefore valid together
    //   with done.
    // - An abort clears pass and the error fields but keeps the rows that
    //   have been captured so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec      <= '0;
            r_cnt      <= '0;
            r_expected <= '0;
            r_table    <= '0;
            r_errCount <= '0;
            r_firstErr <= '0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_expected <= bus.expected;
                        r_table    <= '0;
                        r_errCount <= '0;
                        r_firstErr <= '0;
                        r_pass     <= 1'b0;
                        r_vec      <= '0;
                        r_cnt      <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_pass     <= 1'b0;
                        r_errCount <= '0;
                        r_firstErr <= '0;
                        r_vec      <= '0;
                        r_cnt      <= '0;
                    end else if (w_sampleEdge) begin
                        r_table[r_vec] <= bus.dut_out;
                        r_errCount     <= w_errNext;
                        if (w_mismatch && (r_errCount == '0)) begin
                            r_firstErr <= r_vec;
                        end
                        r_cnt <= '0;
                        if (r_vec == VEC_LAST) begin
                            r_pass <= (w_errNext == '0);
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_checker
//
// Testbench for tt_sweep_checker. It uses two checker instances that share
// one clock and one reset:
//   A: N_IN=3, SETTLE_CYCLES=4, logic block modelled as output=1 for
//      vectors 2, 4 and 6 (table 8'h54)
//   B: N_IN=3, SETTLE_CYCLES=1, logic block output stuck at 1
// Each accepted sweep pushes its hand-computed result, including the cycle
// in which done must appear, into a per-instance queue. A monitor pops from
// that queue on every done pulse and compares.
// ---------------------------------------------------------------------------
module tb_tt_sweep_checker;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [3:0] errs;
        logic [2:0] first;
        int         doneCycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   checks     = 0;
    int   errors     = 0;
    int   cycA       = 0;
    int   doneCountA = 0;
    int   doneCountB = 0;
    int   acceptA    = 0;
    int   acceptB    = 0;

    exp_t qA[$];
    exp_t qB[$];

    logic [7:0] modelA = 8'h54;

    tt_sweep_checker_if #(.N_IN(3)) busA ();
    tt_sweep_checker_if #(.N_IN(3)) busB ();

    assign busA.dut_out = modelA[busA.dut_in];
    assign busB.dut_out = 1'b1;

    tt_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(4)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    tt_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    // Free-running clock, 10 time units per period, first rising edge at 5.
    always #5 clk = ~clk;

    // Counts rising edges so that done latency can be checked in absolute
    // cycles.
    always @(posedge clk) cycA <= cycA + 1;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor for instance A.
    always @(negedge clk) begin : monA
        exp_t e;
        if (busA.done) begin
            if (qA.size() == 0) begin
                checkOutput("A unexpected done", 32'(busA.done), 32'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("A table", 32'(busA.meas_table), 32'(e.tbl));
                checkOutput("A pass", 32'(busA.pass), 32'(e.pass));
                checkOutput("A err_count", 32'(busA.err_count), 32'(e.errs));
                checkOutput("A first_err", 32'(busA.first_err), 32'(e.first));
                checkOutput("A done cycle", cycA, e.doneCycle);
                checkOutput("A busy at done", 32'(busA.busy), 32'd0);
                checkOutput("A dut_in at done", 32'(busA.dut_in), 32'd0);
            end
            doneCountA <= doneCountA + 1;
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge clk) begin : monB
        exp_t e;
        if (busB.done) begin
            if (qB.size() == 0) begin
                checkOutput("B unexpected done", 32'(busB.done), 32'd0);
            end else begin
                e = qB.pop_front();
                checkOutput("B table", 32'(busB.meas_table), 32'(e.tbl));
                checkOutput("B pass", 32'(busB.pass), 32'(e.pass));
                checkOutput("B err_count", 32'(busB.err_count), 32'(e.errs));
                checkOutput("B first_err", 32'(busB.first_err), 32'(e.first));
                checkOutput("B done cycle", cycA, e.doneCycle);
            end
            doneCountB <= doneCountB + 1;
        end
    end

    // Drives start into A at a falling edge and returns 1 time unit after the
    // accepting rising edge. acceptA is set to that edge.
    task automatic applyStimulus(input logic [7:0] exp, input bit hold);
        @(negedge clk);
        busA.expected = exp;
        busA.start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) busA.start = 1'b0;
        acceptA = cycA;
        checkOutput("A busy after start", 32'(busA.busy), 32'd1);
    endtask

    task automatic applyStimulusB(input logic [7:0] exp);
        @(negedge clk);
        busB.expected = exp;
        busB.start    = 1'b1;
        @(posedge clk);
        #1;
        busB.start = 1'b0;
        acceptB = cycA;
    endtask

    task automatic waitDoneA(input int target, input int budget);
        int n = 0;
        while (doneCountA < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("A done count", doneCountA, target);
    endtask

    task automatic waitDoneB(input int target, input int budget);
        int n = 0;
        while (doneCountB < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("B done count", doneCountB, target);
    endtask

    task automatic waitVecA(input logic [2:0] v, input int budget);
        int n = 0;
        while (busA.dut_in != v && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("A reach vector", 32'(busA.dut_in), 32'(v));
    endtask

    task automatic checkAllZeroA(input string tag);
        checkOutput({tag, " dut_in"}, 32'(busA.dut_in), 32'd0);
        checkOutput({tag, " busy"}, 32'(busA.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(busA.done), 32'd0);
        checkOutput({tag, " pass"}, 32'(busA.pass), 32'd0);
        checkOutput({tag, " table"}, 32'(busA.meas_table), 32'd0);
        checkOutput({tag, " err_count"}, 32'(busA.err_count), 32'd0);
        checkOutput({tag, " first_err"}, 32'(busA.first_err), 32'd0);
    endtask

    // Watchdog so that the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        busA.start = 1'b0; busA.abort = 1'b0; busA.expected = '0;
        busB.start = 1'b0; busB.abort = 1'b0; busB.expected = '0;

        // Reset state.
        #1 rst = 1'b1;
        #2;
        checkAllZeroA("reset");
        checkOutput("B reset busy", 32'(busB.busy), 32'd0);
        #9 rst = 1'b0;

        // Sweep 1: matching table. Also checks the vector stepping.
        applyStimulus(8'h54, 1'b0);
        qA.push_back('{tbl: 8'h54, pass: 1'b1, errs: 4'd0, first: 3'd0,
                       doneCycle: acceptA + 32});
        for (int i = 0; i < 32; i++) begin
            checkOutput("A dut_in step", 32'(busA.dut_in), 32'(i / 4));
            @(posedge clk);
            #1;
        end
        waitDoneA(1, 10);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("A pass held", 32'(busA.pass), 32'd1);
        checkOutput("A table held", 32'(busA.meas_table), 32'h54);

        // Sweep 2: complementary expected, 6 mismatches, first at vector 1.
        applyStimulus(8'h2A, 1'b0);
        qA.push_back('{tbl: 8'h54, pass: 1'b0, errs: 4'd6, first: 3'd1,
                       doneCycle: acceptA + 32});
        waitDoneA(2, 50);

        // Asynchronous reset in the middle of a sweep, then a clean sweep.
        applyStimulus(8'h54, 1'b0);
        waitVecA(3'd5, 40);
        #2 rst = 1'b1;
        #1;
        checkAllZeroA("mid reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h54, 1'b0);
        qA.push_back('{tbl: 8'h54, pass: 1'b1, errs: 4'd0, first: 3'd0,
                       doneCycle: acceptA + 32});
        waitDoneA(3, 50);

        // Abort at vector 3. A start raised during RUN must not restart it.
        applyStimulus(8'h00, 1'b0);
        waitVecA(3'd1, 10);
        busA.start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        busA.start = 1'b0;
        checkOutput("A start ignored in RUN", 32'(busA.dut_in), 32'd2);
        waitVecA(3'd3, 10);
        busA.abort = 1'b1;
        @(posedge clk);
        #1;
        busA.abort = 1'b0;
        checkOutput("A abort busy", 32'(busA.busy), 32'd0);
        checkOutput("A abort dut_in", 32'(busA.dut_in), 32'd0);
        checkOutput("A abort pass", 32'(busA.pass), 32'd0);
        checkOutput("A abort err_count", 32'(busA.err_count), 32'd0);
        checkOutput("A abort table", 32'(busA.meas_table), 32'h04);
        base = doneCountA;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("A no done after abort", doneCountA, base);

        // Back-to-back: start held high, expected changed mid-sweep.
        applyStimulus(8'h54, 1'b1);
        qA.push_back('{tbl: 8'h54, pass: 1'b1, errs: 4'd0, first: 3'd0,
                       doneCycle: acceptA + 32});
        qA.push_back('{tbl: 8'h54, pass: 1'b0, errs: 4'd6, first: 3'd1,
                       doneCycle: acceptA + 34 + 32});
        busA.expected = 8'h2A;
        repeat (34) @(posedge clk);
        #1;
        busA.expected = 8'h00;
        busA.start    = 1'b0;
        checkOutput("A second sweep running", 32'(busA.busy), 32'd1);
        checkOutput("A second sweep vector", 32'(busA.dut_in), 32'd0);
        waitDoneA(base + 2, 80);

        // Instance B: single settle cycle, output stuck at 1.
        applyStimulusB(8'hFF);
        qB.push_back('{tbl: 8'hFF, pass: 1'b1, errs: 4'd0, first: 3'd0,
                       doneCycle: acceptB + 8});
        waitDoneB(1, 20);
        applyStimulusB(8'h0F);
        qB.push_back('{tbl: 8'hFF, pass: 1'b0, errs: 4'd4, first: 3'd4,
                       doneCycle: acceptB + 8});
        waitDoneB(2, 20);
        applyStimulusB(8'h00);
        qB.push_back('{tbl: 8'hFF, pass: 1'b0, errs: 4'd8, first: 3'd0,
                       doneCycle: acceptB + 8});
        waitDoneB(3, 20);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("A queue drained", qA.size(), 0);
        checkOutput("B queue drained", qB.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
